// File: rtl/alu_calc_pkg.sv
// rtl/alu_calc_pkg.sv - shared op codes, flag indices and hex glyph table for alu_calc_param
package alu_calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Active-low gfedcba glyphs, entry F first so that HEX_SEG[n] selects digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/alu_calc_param_btn_debounce.sv
// rtl/alu_calc_param_btn_debounce.sv - button synchroniser, debouncer and rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // The counter only survives while the synchronised level disagrees with the accepted one.
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = db_d & ~db_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/alu_calc_param.sv
// rtl/alu_calc_param.sv - button-loaded operand ALU with accumulate and 4-digit hex display
module alu_calc_param
    import alu_calc_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REFRESH_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn1,
    input  logic             btn2,
    input  logic             btn_acc,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       flags,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int SHW = $clog2(WIDTH);
    localparam int RW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic p1, p2, pacc;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clk(clk), .rst(rst), .btn_raw(btn1), .pulse(p1)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clk(clk), .rst(rst), .btn_raw(btn2), .pulse(p2)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_acc (
        .clk(clk), .rst(rst), .btn_raw(btn_acc), .pulse(pacc)
    );

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;
    logic [RW-1:0]    ref_q, ref_d;
    logic [1:0]       digit_q, digit_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic [WIDTH:0]   ext;
    logic             carry, ovf;
    logic [15:0]      disp_val;
    logic [3:0]       nib;

    always_comb begin
        a_d = a_q;
        if (p1) begin
            a_d = in;
        end else if (pacc) begin
            a_d = y_q;
        end
        b_d = p2 ? in : b_q;
    end

    always_comb begin
        ext   = '0;
        y_d   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (sel)
            OP_ADD: begin
                ext   = {1'b0, a_q} + {1'b0, b_q};
                y_d   = ext[WIDTH-1:0];
                carry = ext[WIDTH];
                ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                ext   = {1'b0, a_q} - {1'b0, b_q};
                y_d   = ext[WIDTH-1:0];
                carry = ext[WIDTH];
                ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  y_d = a_q & b_q;
            OP_OR:   y_d = a_q | b_q;
            OP_XOR:  y_d = a_q ^ b_q;
            OP_NOT:  y_d = ~a_q;
            OP_SHL:  y_d = a_q << b_q[SHW-1:0];
            OP_SHR:  y_d = a_q >> b_q[SHW-1:0];
            default: y_d = '0;
        endcase
        flags_d         = '0;
        flags_d[FLAG_Z] = (y_d == '0);
        flags_d[FLAG_N] = y_d[WIDTH-1];
        flags_d[FLAG_C] = carry;
        flags_d[FLAG_V] = ovf;
    end

    always_comb begin
        ref_d   = ref_q + 1'b1;
        digit_d = digit_q;
        if (ref_q == RW'(REFRESH_CYCLES - 1)) begin
            ref_d   = '0;
            digit_d = digit_q + 2'd1;
        end
        disp_val = 16'(y_q);
        nib      = disp_val[digit_d*4 +: 4];
        // an and seg are both derived from the next digit index so they switch on the same edge.
        an_d     = ~(4'b0001 << digit_d);
        seg_d    = HEX_SEG[nib];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            flags_q <= 4'b0001;
            ref_q   <= '0;
            digit_q <= '0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            ref_q   <= ref_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign Y     = y_q;
    assign flags = flags_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_alu_calc_param.sv
// tb/tb_alu_calc_param.sv - self-checking bench for alu_calc_param
module tb_alu_calc_param;

    localparam int W   = 8;
    localparam int DEB = 16;
    localparam int REF = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn1, btn2, btn_acc;
    logic [W-1:0] sw;
    logic [2:0]   sel;
    logic [W-1:0] Y;
    logic [3:0]   flags;
    logic [6:0]   seg;
    logic [3:0]   an;

    int checks   = 0;
    int failures = 0;

    bit check_en = 1'b0;
    int exp_a = 0, exp_b = 0;
    int exp_y = 0, exp_f = 1, y_prev = 0;
    int edges = 0;

    alu_calc_param #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
        .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2), .btn_acc(btn_acc),
        .in(sw), .sel(sel), .Y(Y), .flags(flags), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Returns {V,C,N,Z} in bits 11:8 and the 8-bit result in bits 7:0.
    function automatic int model_alu(input int a, input int b, input int s);
        int r, y, c, v, sr;
        c = 0; v = 0; r = 0;
        case (s)
            0: begin
                r  = a + b;
                c  = (r > 255) ? 1 : 0;
                sr = to_signed8(a) + to_signed8(b);
                v  = (sr > 127 || sr < -128) ? 1 : 0;
            end
            1: begin
                r  = a - b;
                c  = (a < b) ? 1 : 0;
                sr = to_signed8(a) - to_signed8(b);
                v  = (sr > 127 || sr < -128) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = a << (b % 8);
            7: r = a >> (b % 8);
            default: r = 0;
        endcase
        y = r & 255;
        return (v << 11) | (c << 10) | (((y >= 128) ? 1 : 0) << 9) | (((y == 0) ? 1 : 0) << 8) | y;
    endfunction

    function automatic int glyph(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advances on each clock edge from what the bench believes A, B and sel are.
    always @(posedge clk) begin
        int r;
        if (rst) begin
            edges  = 0;
            exp_y  = 0;
            exp_f  = 1;
            y_prev = 0;
        end else begin
            edges++;
            y_prev = exp_y;
            r      = model_alu(exp_a, exp_b, sel);
            exp_y  = r & 255;
            exp_f  = (r >> 8) & 15;
        end
    end

    always @(negedge clk) begin
        int dig;
        logic [3:0] an_exp;
        if (check_en && !rst) begin
            dig    = (edges / REF) % 4;
            an_exp = ~(4'b0001 << dig);
            chk("model_y", Y, exp_y);
            chk("model_flags", flags, exp_f);
            chk("model_an", an, an_exp);
            chk("model_seg", seg, glyph((y_prev >> (4 * dig)) & 15));
        end
    end

    // which: 1=btn1, 2=btn2, 3=btn_acc, 4=btn1 and btn_acc together
    task automatic press(input int which, input int val, input int hold);
        int acc_val;
        acc_val  = exp_y;
        check_en = 1'b0;
        sw       = W'(val);
        btn1     = (which == 1 || which == 4);
        btn2     = (which == 2);
        btn_acc  = (which == 3 || which == 4);
        repeat (hold) @(posedge clk);
        #1;
        btn1 = 1'b0; btn2 = 1'b0; btn_acc = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        #1;
        if (which == 1 || which == 4) exp_a = val;
        else if (which == 3) exp_a = acc_val;
        if (which == 2) exp_b = val;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
    endtask

    task automatic sel_and_check(input string name, input int s, input int y, input int f);
        sel = 3'(s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({name, "_y"}, Y, y);
        chk({name, "_flags"}, flags, f);
        #1;
    endtask

    initial begin
        int found;
        logic [3:0] an_last;
        rst = 1'b1; btn1 = 1'b0; btn2 = 1'b0; btn_acc = 1'b0; sw = '0; sel = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", Y, 0);
        chk("reset_flags", flags, 4'b0001);
        chk("reset_an", an, 4'b1110);
        chk("reset_seg", seg, 7'b1000000);
        rst = 1'b0;
        check_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        press(1, 8'h51, 40);
        press(2, 8'h06, 40);
        sel_and_check("add_57", 0, 8'h57, 4'b0000);
        sel_and_check("sub_4b", 1, 8'h4B, 4'b0000);

        press(1, 8'h06, 40);
        press(2, 8'h51, 40);
        sel_and_check("sub_borrow", 1, 8'hB5, 4'b0110);
        press(1, 8'h7F, 40);
        press(2, 8'h01, 40);
        sel_and_check("add_ovf", 0, 8'h80, 4'b1010);
        press(1, 8'hFF, 40);
        sel_and_check("add_wrap", 0, 8'h00, 4'b0101);

        press(1, 8'h51, 40);
        press(2, 8'h03, 40);
        sel_and_check("shl", 6, 8'h88, 4'b0010);
        sel_and_check("shr", 7, 8'h0A, 4'b0000);
        sel_and_check("not", 5, 8'hAE, 4'b0010);
        sel_and_check("and", 2, 8'h01, 4'b0000);
        sel_and_check("or",  3, 8'h53, 4'b0000);
        sel_and_check("xor", 4, 8'h52, 4'b0000);
        sel_and_check("add_54", 0, 8'h54, 4'b0000);

        // Short glitches on btn1 must leave A untouched.
        sw = 8'hAA;
        btn1 = 1'b1; repeat (5) @(posedge clk); #1;
        btn1 = 1'b0; repeat (3) @(posedge clk); #1;
        btn1 = 1'b1; repeat (5) @(posedge clk); #1;
        btn1 = 1'b0; repeat (DEB + 10) @(posedge clk);
        @(negedge clk);
        chk("glitch_y", Y, 8'h54);
        #1;
        press(1, 8'hAA, 40);
        sel_and_check("load_aa", 0, 8'hAD, 4'b0010);

        press(1, 8'h51, 40);
        press(2, 8'h06, 40);
        sel_and_check("pre_acc", 0, 8'h57, 4'b0000);
        press(3, 8'h00, 40);
        sel_and_check("acc_once", 0, 8'h5D, 4'b0000);
        press(4, 8'h33, 40);
        sel_and_check("btn1_wins", 0, 8'h39, 4'b0000);

        press(1, 8'h51, 40);
        sel_and_check("disp_y", 0, 8'h57, 4'b0000);
        found = 0;
        an_last = an;
        for (int i = 0; i < 4 * REF + 4 && found == 0; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && an_last == 4'b0111) found = 1;
            an_last = an;
        end
        chk("disp_align_found", found, 1);
        if (found == 1) begin
            chk("disp_d0_an", an, 4'b1110); chk("disp_d0_seg", seg, 7'b1111000);
            repeat (REF) @(posedge clk); @(negedge clk);
            chk("disp_d1_an", an, 4'b1101); chk("disp_d1_seg", seg, 7'b0010010);
            repeat (REF) @(posedge clk); @(negedge clk);
            chk("disp_d2_an", an, 4'b1011); chk("disp_d2_seg", seg, 7'b1000000);
            repeat (REF) @(posedge clk); @(negedge clk);
            chk("disp_d3_an", an, 4'b0111); chk("disp_d3_seg", seg, 7'b1000000);
            repeat (REF) @(posedge clk); @(negedge clk);
            chk("disp_wrap_an", an, 4'b1110); chk("disp_wrap_seg", seg, 7'b1111000);
        end
        @(posedge clk); #1;

        // Reset lands mid-debounce and mid-refresh, then btn1 stays held across release.
        sw = 8'h51;
        btn1 = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        check_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_y", Y, 0);
        chk("async_rst_flags", flags, 4'b0001);
        chk("async_rst_an", an, 4'b1110);
        chk("async_rst_seg", seg, 7'b1000000);
        exp_a = 0; exp_b = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (DEB + 3) @(posedge clk);
        @(negedge clk);
        chk("rel_before_load", Y, 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("rel_load_latency", Y, 8'h51);
        repeat (20) @(posedge clk);
        #1;
        btn1 = 1'b0;
        repeat (DEB + 6) @(posedge clk);
        #1;
        exp_a = 8'h51;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
